// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length-prefixed big-endian byte stream in,
// sequential word writes out, core held in reset until a checksum-verified load.
module imem_loader #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK} state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic              im_we_q;
    logic [ADDR_W-1:0] im_waddr_q;
    logic [31:0]       im_wdata_q;
    logic              cpu_rst_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       nwords_q;
    logic [15:0]       widx_q;
    logic [1:0]        bcnt_q;
    logic [23:0]       asm_q;
    logic [7:0]        xor_q;
    logic [31:0]       tmo_q;

    logic              accept;
    logic [15:0]       len_d;
    logic [15:0]       widx_d;
    logic              len_bad;
    logic              tmo_expired;

    assign accept  = in_valid & in_ready_q;
    assign len_d   = {len_hi_q, in_data};
    assign widx_d  = widx_q + 16'd1;
    assign len_bad = (len_d == 16'd0) || (32'(len_d) > 32'(DEPTH));
    // Only an idle cycle can expire the timer; an accepted byte always resets it.
    assign tmo_expired = (TIMEOUT != 0) && (state_q != S_IDLE) && !accept
                         && (tmo_q == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_waddr_q <= '0;
            im_wdata_q <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            len_hi_q   <= '0;
            nwords_q   <= '0;
            widx_q     <= '0;
            bcnt_q     <= '0;
            asm_q      <= '0;
            xor_q      <= '0;
            tmo_q      <= '0;
        end else begin
            im_we_q <= 1'b0;
            if (state_q != S_IDLE)
                tmo_q <= accept ? 32'd0 : tmo_q + 32'd1;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LEN_HI;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        cpu_rst_q  <= 1'b1;
                        widx_q     <= '0;
                        bcnt_q     <= '0;
                        xor_q      <= '0;
                        tmo_q      <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= in_data;
                        state_q  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if (len_bad) begin
                            state_q    <= S_IDLE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            nwords_q <= len_d;
                            bcnt_q   <= '0;
                            state_q  <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        xor_q  <= xor_q ^ in_data;
                        asm_q  <= {asm_q[15:0], in_data};
                        bcnt_q <= bcnt_q + 2'd1;
                        if (bcnt_q == 2'd3) begin
                            im_we_q    <= 1'b1;
                            im_waddr_q <= widx_q[ADDR_W-1:0];
                            im_wdata_q <= {asm_q, in_data};
                            widx_q     <= widx_d;
                            if (widx_d == nwords_q)
                                state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        state_q    <= S_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_data == xor_q) begin
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (tmo_expired) begin
                state_q    <= S_IDLE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
            end
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_waddr = im_waddr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader; the writer side of the instruction-memory port that the single-cycle core only reads.
- Receives a byte stream over a valid/ready interface, assembles big-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Holds the core in reset while loading and releases it only after a checksum-verified load.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; DEPTH = 2**ADDR_W words (4 KB at default).
- TIMEOUT, 100000, max idle cycles between accepted bytes while busy; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid & in_ready.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_waddr  output  ADDR_W  word address for the write.
- im_wdata  output  32  word data for the write.
- cpu_rst  output  1  reset to the core; 1 = core held in reset.
- busy  output  1  load in progress.
- done  output  1  sticky; last load succeeded.
- err  output  1  sticky; last load failed.

Behaviour:
- Reset values: in_ready=0, im_we=0, im_waddr=0, im_wdata=0, cpu_rst=1, busy=0, done=0, err=0, state IDLE. All counters, the checksum accumulator and the timeout counter are 0.
- A reset in any state returns every output to these values at the next edge. A write strobe in flight is dropped.
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then 4N data bytes, MSB first per word, then 1 checksum byte equal to the XOR of all 4N data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK.
- IDLE:
  - in_ready=0.
  - start=1 -> LEN_HI. Same edge: busy=1, done=0, err=0, cpu_rst=1, word index=0, XOR=0.
  - start while not IDLE is ignored.
- LEN_HI and LEN_LO:
  - in_ready=1; each accepted byte is latched.
  - After LEN_LO: if N==0 or N>DEPTH -> fail. Otherwise -> DATA with byte count 0.
- DATA:
  - in_ready=1. Each accepted byte shifts into the assembly register and XORs into the checksum.
  - On the 4th byte of a word, accepted at edge T: in the cycle after T, im_we=1 for exactly one cycle with im_waddr=word index and im_wdata=assembled word. The word index increments.
  - Byte acceptance continues without stall during the write cycle.
  - After byte 4N -> CHK.
- CHK:
  - in_ready=1. The checksum byte is accepted at edge C; in the cycle after C, in_ready=0, state=IDLE, busy=0.
  - Match -> done=1, cpu_rst=0.
  - Mismatch -> fail.
  - The final data word's im_we occurs in the first CHK cycle, always before the checksum can be accepted.
- Fail: next cycle state=IDLE, err=1, busy=0, in_ready=0, cpu_rst stays 1. Words already written are not rolled back.
- Timeout:
  - The counter runs in LEN_HI, LEN_LO, DATA and CHK, and clears on each accepted byte.
  - Reaching TIMEOUT -> fail. TIMEOUT=0 disables it.
- cpu_rst stays 1 from reset until the first successful load. A new start re-asserts it for the whole load.
- Extra bytes offered while IDLE are not accepted (in_ready=0).
- im_waddr and im_wdata hold their last values while im_we=0.

Test Plan:
- Reset -> check every output at its reset value. Then start with no input for TIMEOUT cycles (TIMEOUT=16) -> err=1 at cycle 17 after start, cpu_rst=1, no im_we.
- start, then bytes 00 02 20 08 00 05 01 09 40 20 45 with in_valid held high -> im_we pulses with (addr 0, data 0x20080005), then (addr 1, data 0x01094020). Next cycle after the checksum: done=1, err=0, busy=0, cpu_rst=0.
- Same stream with checksum 0x44 -> both words written, err=1, done=0, cpu_rst=1.
- Length 00 00, and separately 04 01 (ADDR_W=10) -> err=1 the cycle after LEN_LO accepted, no im_we, in_ready=0.
- Stream from the second scenario with in_valid randomly gapped (gaps under TIMEOUT) -> identical writes and done=1. A start pulse mid-load has no effect.
- rst asserted after 5 data bytes -> next cycle all outputs at reset values. A following full load from the second scenario succeeds with writes starting at addr 0.
